my_if_packer: RTL and testbench

Downstream consumer of the `my_if` valid-only stream: it accepts one `DW`-bit beat per asserted `valid` through a `my_if.slave_mp` port. It packs `RATIO` consecutive beats into one `DW*RATIO`-bit word and buffers completed words in a small FIFO. Words leave on a valid/ready output toward wide-datapath stages. The input has no backpressure, so the block drops words on FIFO overflow and flags the loss.

---
 rtl/my_if_packer_if.sv | 19 +
 rtl/my_if_packer.sv | 113 +++++++++++
 tb/tb_my_if_packer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/my_if_packer_if.sv
// Narrow valid-only beat stream between a producer and a packer.
// Carries one DW-bit beat per cycle in which valid is high.
// No backpressure: the consumer must take every qualified beat.
interface my_if #(
  parameter int DW = 8
);
  logic          valid;
  logic [DW-1:0] data;

  modport master_mp (
    output valid,
    output data
  );

  modport slave_mp (
    input valid,
    input data
  );
endinterface

// File: rtl/my_if_packer.sv
// Packs RATIO narrow beats into one wide word and buffers words in a DEPTH-entry FIFO.
// Latency: word visible on out_valid/out_data right after the edge that samples its last beat.
// Backpressure: out_ready stalls the FIFO only; input never stalls, full FIFO drops words (sticky overflow).
module my_if_packer #(
  parameter int DW    = 8,
  parameter int RATIO = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  my_if.slave_mp                       in_if,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DW*RATIO-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow,
  input  logic                         clr_overflow
);

  localparam int CW = $clog2(RATIO);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int WW = DW * RATIO;
  localparam int AW = DW * (RATIO - 1);

  logic [CW-1:0] r_beat_cnt;
  logic [AW-1:0] r_acc;
  logic [WW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_overflow;

  logic          w_last;
  logic          w_push_req;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [WW-1:0] w_word;

  assign w_last     = (r_beat_cnt == CW'(RATIO - 1));
  assign w_push_req = in_if.valid && w_last;
  assign w_word     = {in_if.data, r_acc};

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_pop   = !w_empty && out_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign w_push  = rst_n && w_push_req && (!w_full || w_pop);
  assign w_drop  = w_push_req && w_full && !w_pop;

  // Beat counter and partial-word assembly; the final beat bypasses acc straight into the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
      r_acc      <= '0;
    end else if (in_if.valid) begin
      if (w_last) begin
        r_beat_cnt <= '0;
      end else begin
        r_acc[int'(r_beat_cnt)*DW +: DW] <= in_if.data;
        r_beat_cnt                       <= r_beat_cnt + 1'b1;
      end
    end
  end

  // Word storage; contents are don't-care until written, so no reset here.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); occupancy tracked separately.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky drop flag; a drop in the clearing cycle keeps it set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign level     = r_level;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_my_if_packer.sv
// Directed table-driven bench for my_if_packer (DW=8, RATIO=4, DEPTH=4).
// Each row: inputs for one cycle, outputs expected #1 after the following rising edge.
// Reset cases are driven by hand after the table.
module tb_my_if_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  level;
  logic        overflow;
  logic        clr_overflow = 1'b0;

  int total = 0;
  int bad   = 0;

  my_if #(.DW(8)) u_if ();

  my_if_packer #(.DW(8), .RATIO(4), .DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_if        (u_if),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .level        (level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        r;
    logic        c;
    logic        ev;
    logic [31:0] ed;
    logic [2:0]  el;
    logic        eo;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [7:0] d, input logic r, input logic c,
                     input logic ev, input logic [31:0] ed, input logic [2:0] el, input logic eo);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.c = c;
    t.ev = ev; t.ed = ed; t.el = el; t.eo = eo;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic c);
    u_if.valid   = v;
    u_if.data    = d;
    out_ready    = r;
    clr_overflow = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int idx, input logic ev, input logic [31:0] ed,
                           input logic [2:0] el, input logic eo);
    chk("out_valid", idx, 32'(out_valid), 32'(ev));
    chk("out_data",  idx, out_data, ed);
    chk("level",     idx, 32'(level), 32'(el));
    chk("overflow",  idx, 32'(overflow), 32'(eo));
  endtask

  // Push four words base, base+1, ... with out_ready low; head becomes the base word.
  task automatic fill4(input logic [7:0] base, input logic eo);
    for (int w = 0; w < 4; w++) begin
      for (int b = 0; b < 4; b++) begin
        int lv;
        lv = (b == 3) ? w + 1 : w;
        add(1'b1, base + 8'(w), 1'b0, 1'b0, lv != 0,
            (lv != 0) ? {4{base}} : 32'h0, 3'(lv), eo);
      end
    end
  endtask

  initial begin
    u_if.valid = 1'b0;
    u_if.data  = 8'h00;

    // Packing order, back-to-back beats.
    add(1, 8'h11, 1, 0, 0, 32'h0, 0, 0);
    add(1, 8'h22, 1, 0, 0, 32'h0, 0, 0);
    add(1, 8'h33, 1, 0, 0, 32'h0, 0, 0);
    add(1, 8'h44, 1, 0, 1, 32'h44332211, 1, 0);
    add(0, 8'h00, 1, 0, 0, 32'h0, 0, 0);

    // Gapped input: junk on data while valid is low must be ignored.
    for (int b = 0; b < 4; b++) begin
      add(1, 8'h11 * 8'(b + 1), 1, 0, b == 3, (b == 3) ? 32'h44332211 : 32'h0, 3'(b == 3), 0);
      if (b < 3) begin
        for (int g = 0; g < 3; g++) add(0, 8'hEE, 1, 0, 0, 32'h0, 0, 0);
      end
    end
    add(0, 8'h00, 1, 0, 0, 32'h0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 32'h0, 0, 0);

    // Fill then overflow: word i = {4{i}}, fifth word dropped.
    for (int w = 0; w < 5; w++) begin
      for (int b = 0; b < 4; b++) begin
        int lv;
        lv = (b == 3) ? ((w + 1 > 4) ? 4 : w + 1) : w;
        add(1, 8'(w), 0, 0, lv != 0, 32'h0, 3'(lv), (w == 4) && (b == 3));
      end
    end
    add(0, 8'h00, 0, 0, 1, 32'h00000000, 4, 1);
    add(0, 8'h00, 1, 0, 1, 32'h01010101, 3, 1);
    add(0, 8'h00, 1, 0, 1, 32'h02020202, 2, 1);
    add(0, 8'h00, 1, 0, 1, 32'h03030303, 1, 1);
    add(0, 8'h00, 1, 0, 0, 32'h0, 0, 1);
    add(0, 8'h00, 1, 0, 0, 32'h0, 0, 1);
    // Clear with no drop.
    add(0, 8'h00, 0, 1, 0, 32'h0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 32'h0, 0, 0);

    // Full with simultaneous pop: fifth word accepted, read last after wrap.
    fill4(8'h10, 1'b0);
    add(1, 8'h14, 0, 0, 1, 32'h10101010, 4, 0);
    add(1, 8'h14, 0, 0, 1, 32'h10101010, 4, 0);
    add(1, 8'h14, 0, 0, 1, 32'h10101010, 4, 0);
    add(1, 8'h14, 1, 0, 1, 32'h11111111, 4, 0);
    add(0, 8'h00, 1, 0, 1, 32'h12121212, 3, 0);
    add(0, 8'h00, 1, 0, 1, 32'h13131313, 2, 0);
    add(0, 8'h00, 1, 0, 1, 32'h14141414, 1, 0);
    add(0, 8'h00, 1, 0, 0, 32'h0, 0, 0);

    // Clear in the same cycle as a drop: set wins; drain keeps the flag.
    fill4(8'h20, 1'b0);
    add(1, 8'h24, 0, 0, 1, 32'h20202020, 4, 0);
    add(1, 8'h24, 0, 0, 1, 32'h20202020, 4, 0);
    add(1, 8'h24, 0, 0, 1, 32'h20202020, 4, 0);
    add(1, 8'h24, 0, 1, 1, 32'h20202020, 4, 1);
    add(0, 8'h00, 0, 0, 1, 32'h20202020, 4, 1);
    add(0, 8'h00, 1, 0, 1, 32'h21212121, 3, 1);
    add(0, 8'h00, 1, 0, 1, 32'h22222222, 2, 1);
    add(0, 8'h00, 1, 0, 1, 32'h23232323, 1, 1);
    add(0, 8'h00, 1, 0, 0, 32'h0, 0, 1);

    // Reset state.
    rst_n = 1'b0;
    drive(0, 8'h00, 0, 0);
    drive(0, 8'h00, 0, 0);
    check_all(-1, 0, 32'h0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].c);
      check_all(i, vecs[i].ev, vecs[i].ed, vecs[i].el, vecs[i].eo);
    end

    // Reset mid-word (overflow is still set from above); reset beats a valid beat.
    drive(1, 8'hAA, 1, 0);
    drive(1, 8'hBB, 1, 0);
    chk("midword_level", -2, 32'(level), 32'h0);
    rst_n = 1'b0;
    drive(1, 8'hCC, 1, 0);
    check_all(-3, 0, 32'h0, 0, 0);
    rst_n = 1'b1;
    drive(1, 8'h01, 0, 0);
    check_all(-4, 0, 32'h0, 0, 0);
    drive(1, 8'h02, 0, 0);
    drive(1, 8'h03, 0, 0);
    check_all(-5, 0, 32'h0, 0, 0);
    drive(1, 8'h04, 0, 0);
    check_all(-6, 1, 32'h04030201, 1, 0);
    drive(0, 8'h00, 0, 0);
    check_all(-7, 1, 32'h04030201, 1, 0);
    drive(0, 8'h00, 1, 0);
    check_all(-8, 0, 32'h0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
